// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO with flush abort.
// Define MULDIV_DIV_EARLY_EN to let divides with |a|<|b| skip the iterative phase.
module muldiv_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q, b_q, quo_q, rem_q, hi_q, lo_q;
  logic        sgn_q, qneg_q, rneg_q, done_q;
  logic        neg_a, neg_b, rem_ge;
  logic [31:0] mag_a, mag_b, rem_sub;
  logic [32:0] rem_sh;
  logic [63:0] prod;
  assign neg_a   = ~op[0] & src_a[31];
  assign neg_b   = ~op[0] & src_b[31];
  assign mag_a   = neg_a ? -src_a : src_a;
  assign mag_b   = neg_b ? -src_b : src_b;
  // a_q doubles as the dividend shift register during DIV
  assign rem_sh  = {rem_q, a_q[31]};
  assign rem_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = 32'(rem_sh - {1'b0, b_q});
  assign prod    = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
  assign busy    = (start && op <= 3'd3) || state_q != IDLE;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start && !flush) begin
          if (op == 3'd4) hi_q <= src_a;
          else if (op == 3'd5) lo_q <= src_a;
          else if (!op[2]) begin
            a_q     <= op[1] ? mag_a : src_a;
            b_q     <= op[1] ? mag_b : src_b;
            sgn_q   <= ~op[0];
            qneg_q  <= neg_a ^ neg_b;
            rneg_q  <= neg_a;
            rem_q   <= '0;
            quo_q   <= '0;
            state_q <= op[1] ? DIV : MUL;
            cnt_q   <= op[1] ? 5'(DIV_ITERS - 1) : 5'(MUL_LAT - 1);
`ifdef MULDIV_DIV_EARLY_EN
            if (op[1] && mag_b != '0 && mag_a < mag_b) begin
              rem_q   <= mag_a;
              state_q <= FIX;
            end
`endif
          end
        end
        MUL: if (flush) state_q <= IDLE;
        else if (cnt_q == '0) begin
          {hi_q, lo_q} <= prod;
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end else cnt_q <= cnt_q - 5'd1;
        DIV: if (flush) state_q <= IDLE;
        else begin
          rem_q <= rem_ge ? rem_sub : rem_sh[31:0];
          quo_q <= {quo_q[30:0], rem_ge};
          a_q   <= a_q << 1;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: if (flush) state_q <= IDLE;
        else begin
          lo_q    <= qneg_q ? -quo_q : quo_q;
          hi_q    <= rneg_q ? -rem_q : rem_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 2;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] hi_m = '0, lo_m = '0;
  int checks = 0, errors = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_hl(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2: return (b == 0) ? {a, (sa < 0) ? 32'd1 : 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
      3'd4: return {a, lo_m};
      3'd5: return {hi_m, a};
      default: return {hi_m, lo_m};
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (o <= 3'd1) return 1 + MUL_LAT;
    if (o > 3'd3) return 0;
    ma = (o == 3'd2 && a[31]) ? -a : a;
    mb = (o == 3'd2 && b[31]) ? -b : b;
`ifdef MULDIV_DIV_EARLY_EN
    if (mb != 0 && ma < mb) return 2;
`endif
    return 34;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp_hl = ref_hl(o, a, b);
    int exp_lat = ref_lat(o, a, b);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 n = busy ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    #1;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " lat"}, 64'(n), 64'(exp_lat));
    check({tag, " done"}, {63'b0, done}, {63'b0, o <= 3'd3});
    check({tag, " hilo"}, {hi, lo}, exp_hl);
    {hi_m, lo_m} = exp_hl;
    if (o <= 3'd3) begin
      @(negedge clk);
      #1 check({tag, " done_drop"}, {63'b0, done}, 64'd0);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    #2 rst = 1'b1;
    #2 check("reset", {busy, done, hi, lo}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'd0, 32'hFFFFFFFF, 32'd2, "mult");
    check("mult const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, "multu");
    check("multu const", {hi, lo}, 64'h00000001_FFFFFFFE);
    do_op(3'd2, -32'sd7, 32'd2, "div_neg");
    check("div_neg const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(3'd3, 32'd100, 32'd7, "divu");
    check("divu const", {hi, lo}, {32'd2, 32'd14});
    do_op(3'd3, 32'd100, 32'd0, "divu_by0");
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    check("div_ovf const", {hi, lo}, {32'd0, 32'h80000000});
    do_op(3'd2, -32'sd5, 32'd0, "div_by0_neg");
    do_op(3'd3, 32'd3, 32'd7, "divu_small");
    do_op(3'd2, 32'd9, -32'sd4, "div_mixed");
    do_op(3'd6, 32'hDEAD, 32'd1, "reserved");
    // flush in the middle of a divide must leave HI/LO untouched
    do_op(3'd4, 32'h11, 32'd0, "mthi");
    do_op(3'd5, 32'h22, 32'd0, "mtlo");
    @(negedge clk);
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1 check("flush pre busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush busy", {63'b0, busy}, 64'd0);
    check("flush hilo", {hi, lo}, {32'h11, 32'h22});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 check("flush no done", {63'b0, done}, 64'd0);
    end
    do_op(3'd5, 32'h33, 32'd0, "mtlo_after_flush");
    check("mtlo const", {hi, lo}, {32'h11, 32'h33});
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd5; src_b = 32'd0;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 check("start_flush busy", {63'b0, busy}, 64'd0);
    // asynchronous reset mid-divide, between clock edges
    do_op(3'd4, 32'h55, 32'd0, "mthi2");
    @(negedge clk);
    start = 1'b1; op = 3'd2; src_a = 32'd12345; src_b = 32'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #1 check("rst pre busy", {63'b0, busy}, 64'd1);
    #1 rst = 1'b1;
    #1 check("rst async", {busy, done, hi, lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    do_op(3'd3, 32'd100, 32'd7, "divu_after_rst");
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 30));
      do_op(ro, ra, rb, "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
